// File: rtl/inv_mix_columns_iter_pkg.sv
// Shared decipher types: byte/column/state views of the AES state, FSM encoding,
// and the xtime / column-slice helpers used by the InvMixColumns engine.
package inv_mix_columns_iter_pkg;

  typedef logic [7:0] byte_t;
  // Element 0 sits in the MSBs so a column slice maps straight onto row 0..3.
  typedef byte_t [0:3] column_t;
  typedef logic [127:0] state_t;

  localparam byte_t AES_POLY = 8'h1b;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } fsm_t;

  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic column_t get_col(input state_t s, input logic [1:0] c);
    return column_t'(s[127 - 32 * int'(c) -: 32]);
  endfunction

  function automatic state_t set_col(input state_t s, input logic [1:0] c, input column_t v);
    state_t r;
    r = s;
    r[127 - 32 * int'(c) -: 32] = v;
    return r;
  endfunction

endpackage

// File: rtl/inv_mix_column.sv
// Combinational InvMixColumns on a single column; constant multipliers are
// xtime chains (x2, x4, x8) combined by XOR, no tables.
module inv_mix_column
  import inv_mix_columns_iter_pkg::*;
(
  input  column_t col_i,
  output column_t col_o
);

  byte_t x2 [4];
  byte_t x4 [4];
  byte_t x8 [4];
  byte_t m9 [4];
  byte_t mb [4];
  byte_t md [4];
  byte_t me [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      x2[i] = xtime(col_i[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      m9[i] = x8[i] ^ col_i[i];
      mb[i] = x8[i] ^ x2[i] ^ col_i[i];
      md[i] = x8[i] ^ x4[i] ^ col_i[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    // Circulant matrix: row r weights are 0e,0b,0d,09 rotated right by r.
    for (int r = 0; r < 4; r++) begin
      col_o[r] = me[r] ^ mb[(r + 1) % 4] ^ md[(r + 2) % 4] ^ m9[(r + 3) % 4];
    end
  end

endmodule

// File: rtl/inv_mix_columns_iter.sv
// Iterative AES InvMixColumns: result valid 4/COLS_PER_CYCLE edges after accept.
// Output held stable until out_ready; a new state is taken in the same cycle the result drains.
module inv_mix_columns_iter
  import inv_mix_columns_iter_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_GRP = 2'(4 - COLS_PER_CYCLE);

  fsm_t       fsm_q, fsm_d;
  state_t     data_q, data_d;
  logic [1:0] cnt_q, cnt_d;

  column_t col_in  [COLS_PER_CYCLE];
  column_t col_out [COLS_PER_CYCLE];

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    assign col_in[g] = get_col(data_q, cnt_q + 2'(g));
    inv_mix_column u_col (
      .col_i(col_in[g]),
      .col_o(col_out[g])
    );
  end

  assign in_ready  = (fsm_q == ST_IDLE) || ((fsm_q == ST_DONE) && out_ready);
  assign out_valid = (fsm_q == ST_DONE);
  assign busy      = (fsm_q == ST_BUSY);
  assign out_state = data_q;

  always_comb begin
    fsm_d  = fsm_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    case (fsm_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d = in_state;
          cnt_d  = 2'd0;
          fsm_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
          data_d = set_col(data_d, cnt_q + 2'(g), col_out[g]);
        end
        cnt_d = cnt_q + STEP;
        if (cnt_q == LAST_GRP) begin
          cnt_d = 2'd0;
          fsm_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            data_d = in_state;
            cnt_d  = 2'd0;
            fsm_d  = ST_BUSY;
          end else begin
            fsm_d  = ST_IDLE;
          end
        end
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q  <= ST_IDLE;
      data_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      fsm_q  <= fsm_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// Scoreboard bench: three engines (1, 2, 4 columns per cycle); expected results
// are queued at acceptance and popped by a monitor when each output drains.
module tb_inv_mix_columns_iter;

  logic         clk;
  logic         rst;
  logic         iv   [3];
  logic         ir   [3];
  logic [127:0] ist  [3];
  logic         ov   [3];
  logic         ordy [3];
  logic [127:0] ost  [3];
  logic         bz   [3];

  int total = 0;
  int bad   = 0;

  logic [127:0] q0 [$];
  logic [127:0] q1 [$];
  logic [127:0] q2 [$];

  inv_mix_columns_iter #(.COLS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_state(ist[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_state(ost[0]), .busy(bz[0]));
  inv_mix_columns_iter #(.COLS_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_state(ist[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_state(ost[1]), .busy(bz[1]));
  inv_mix_columns_iter #(.COLS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_state(ist[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_state(ost[2]), .busy(bz[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int k, input logic [127:0] e);
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic pop_chk(input int k, input logic [127:0] act);
    logic [127:0] e;
    int sz;
    case (k)
      0: sz = q0.size();
      1: sz = q1.size();
      default: sz = q2.size();
    endcase
    if (sz == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_output dut%0d: got %h with empty scoreboard", k, act);
    end else begin
      case (k)
        0: e = q0.pop_front();
        1: e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      chk($sformatf("out_state dut%0d", k), act, e);
    end
  endtask

  // Monitor: the negedge view of valid/ready is what the next posedge commits.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        if (ov[k] && ordy[k]) pop_chk(k, ost[k]);
      end
    end
  end

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Forward MixColumns reference, used to build inputs for the round trip.
  function automatic logic [127:0] fwd_mix(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      r[127 - 32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      r[119 - 32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      r[111 - 32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      r[103 - 32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return r;
  endfunction

  task automatic send(input int k, input logic [127:0] s, input logic [127:0] e);
    int n;
    n = 0;
    iv[k]  = 1'b1;
    ist[k] = s;
    forever begin
      @(negedge clk);
      if (ir[k]) break;
      n++;
      if (n > 50) break;
    end
    if (n > 50) begin
      total++;
      bad++;
      $display("FAIL accept_timeout dut%0d: in_ready never rose, required 1", k);
    end else begin
      push_exp(k, e);
    end
    @(posedge clk);
    #1;
    iv[k] = 1'b0;
  endtask

  task automatic wait_valid(input int k, output int n);
    n = 0;
    while (!ov[k] && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  localparam logic [127:0] V1_IN  = 128'h8e4da1bc_00000000_00000000_00000000;
  localparam logic [127:0] V1_OUT = 128'hdb135345_00000000_00000000_00000000;
  localparam logic [127:0] V4_IN  = 128'h9fdc589d_01010101_c6c6c6c6_d5d5d7d6;
  localparam logic [127:0] V4_OUT = 128'hf20a225c_01010101_c6c6c6c6_d4d4d4d5;

  initial begin
    int n;
    logic [127:0] orig;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; ist[k] = '0; ordy[k] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset in_ready dut%0d", k), 128'(ir[k]), 128'd1);
      chk($sformatf("reset out_valid dut%0d", k), 128'(ov[k]), 128'd0);
      chk($sformatf("reset busy dut%0d", k), 128'(bz[k]), 128'd0);
      chk($sformatf("reset out_state dut%0d", k), ost[k], 128'd0);
    end

    // Single column, latency 4
    send(0, V1_IN, V1_OUT);
    chk("busy after accept", 128'(bz[0]), 128'd1);
    wait_valid(0, n);
    chk("latency cpc1 single", 128'(n), 128'd4);
    send(0, V4_IN, V4_OUT);
    wait_valid(0, n);
    chk("latency cpc1 full", 128'(n), 128'd4);
    send(1, V4_IN, V4_OUT);
    wait_valid(1, n);
    chk("latency cpc2", 128'(n), 128'd2);
    send(2, V4_IN, V4_OUT);
    wait_valid(2, n);
    chk("latency cpc4", 128'(n), 128'd1);
    send(2, V1_IN, V1_OUT);
    send(1, V1_IN, V1_OUT);
    repeat (3) @(posedge clk);
    #1;

    // Backpressure in DONE, then back-to-back acceptance as the result drains
    ordy[0] = 1'b0;
    send(0, V4_IN, V4_OUT);
    wait_valid(0, n);
    chk("latency stalled run", 128'(n), 128'd4);
    iv[0]  = 1'b1;
    ist[0] = V1_IN;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall out_valid", 128'(ov[0]), 128'd1);
      chk("stall out_state", ost[0], V4_OUT);
      chk("stall in_ready", 128'(ir[0]), 128'd0);
    end
    @(posedge clk);
    #1;
    ordy[0] = 1'b1;
    @(negedge clk);
    chk("b2b in_ready", 128'(ir[0]), 128'd1);
    if (ir[0]) push_exp(0, V1_OUT);
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    chk("b2b busy", 128'(bz[0]), 128'd1);
    chk("b2b out_valid", 128'(ov[0]), 128'd0);
    wait_valid(0, n);
    chk("b2b latency", 128'(n), 128'd4);
    repeat (2) @(posedge clk);
    #1;

    // Reset after two columns have been written
    send(0, V4_IN, V4_OUT);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    if (q0.size() > 0) void'(q0.pop_back());
    chk("midrst out_valid", 128'(ov[0]), 128'd0);
    chk("midrst in_ready", 128'(ir[0]), 128'd1);
    chk("midrst busy", 128'(bz[0]), 128'd0);
    chk("midrst out_state", ost[0], 128'd0);
    send(0, V4_IN, V4_OUT);
    wait_valid(0, n);
    chk("post-reset latency", 128'(n), 128'd4);

    // Round trip through the forward transform
    for (int i = 0; i < 1000; i++) begin
      orig = {$urandom, $urandom, $urandom, $urandom};
      send(0, fwd_mix(orig), orig);
    end
    for (int i = 0; i < 200; i++) begin
      orig = {$urandom, $urandom, $urandom, $urandom};
      send(1, fwd_mix(orig), orig);
      orig = {$urandom, $urandom, $urandom, $urandom};
      send(2, fwd_mix(orig), orig);
    end

    n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("drain dut0", 128'(q0.size()), 128'd0);
    chk("drain dut1", 128'(q1.size()), 128'd0);
    chk("drain dut2", 128'(q2.size()), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
